sync_fifo_param: RTL
====================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 6, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two >=2.
REQ-003 Parameter AF_THRESH, default DEPTH-2, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 2, almost_empty asserts when count <= AE_THRESH.
REQ-005 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Ports, in order:
- clk  in  1  single clock, all logic on rising edge.
- srst_n  in  1  synchronous, active-low reset.
- write_enable  in  1  write request.
- read_enable  in  1  read request (FWFT=1: acknowledge of the current head word).
- clr_err  in  1  clears overflow/underflow.
- data_i  in  DATA_W  write data.
- data_o  out  DATA_W  read data.
- data_valid  out  1  data_o holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  programmable threshold flag.
- almost_empty  out  1  programmable threshold flag.
- count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky, write attempted while full.
- underflow  out  1  sticky, read attempted while empty.

Function
REQ-007 Write SHALL be accepted iff write_enable=1 and full=0; data_i is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-008 Read SHALL be accepted iff read_enable=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-009 full is evaluated from the registered flag of the current cycle; a write while full SHALL be rejected even if a read is accepted in the same cycle.
REQ-010 count next = count + (write accepted) - (read accepted); simultaneous accepted read and write SHALL leave count unchanged.
REQ-011 full, empty, almost_full and almost_empty SHALL be registered and derived from count next, so they are valid the cycle after the causing access.
REQ-012 FWFT=0: on an accepted read, data_o SHALL load mem[rd_ptr] and data_valid SHALL be 1 in the next cycle. Otherwise data_valid=0 and data_o holds its last value.
REQ-013 FWFT=1: data_o SHALL equal mem[rd_ptr] and data_valid SHALL equal !empty. A word written into an empty FIFO SHALL appear on data_o one cycle after the write.
REQ-014 Words SHALL be read in exact write order, including across pointer wrap-around.
REQ-015 overflow SHALL set on write_enable=1 with full=1, and underflow SHALL set on read_enable=1 with empty=1; both hold until clr_err=1.
REQ-016 A set condition in the same cycle as clr_err SHALL win, so the flag stays 1.
REQ-017 Rejected accesses SHALL NOT change pointers, count, memory or data_o.
REQ-018 Storage SHALL be inferable as block RAM; memory contents are not reset.

Reset
REQ-019 When srst_n=0 at a clock edge, the following SHALL take effect next cycle regardless of other inputs: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_valid=0, data_o=0.
REQ-020 Reset mid-operation SHALL discard all stored words; after reset, reads return only data written after reset.

Verification
REQ-021 DEPTH=8, AF_THRESH=6: reset, then 8 consecutive writes 0x01..0x08 -> almost_full=1 the cycle after the 6th write; full=1 and count=8 the cycle after the 8th write.
REQ-022 FIFO full, then write 0x2A -> rejected, overflow=1, count=8; draining yields 0x01..0x08 with no 0x2A; clr_err=1 -> overflow=0.
REQ-023 FWFT=0: write 0x11, 0x22, then 2 reads -> data_o=0x11 with data_valid=1 one cycle after the first read, then 0x22; empty=1 afterwards.
REQ-024 FWFT=1: write 0x15 into empty FIFO -> next cycle data_o=0x15, data_valid=1, empty=0, with no read issued.
REQ-025 count=3, then simultaneous read+write for 12 cycles (pointers wrap) -> count stays 3, and the output sequence matches input order.
REQ-026 read_enable=1 on empty FIFO -> underflow=1, data_valid=0, pointers unchanged. Separately, srst_n=0 at count=5 -> next cycle count=0, empty=1, flags cleared.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with occupancy count, programmable threshold
// flags, sticky error flags and a selectable registered or fall-through read port.
module sync_fifo_param #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       write_enable,
  input  logic                       read_enable,
  input  logic                       clr_err,
  input  logic [DATA_W-1:0]          data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CW-1:0]     w_count_next;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_wr_acc     = 1'b0;
    w_rd_acc     = 1'b0;
    w_count_next = r_count;
    // Acceptance uses the registered flags only, so a write while full is
    // refused even when a read frees a slot in the same cycle.
    w_wr_acc     = write_enable & ~r_full;
    w_rd_acc     = read_enable & ~r_empty;
    w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  end

  // NOTE: the storage array has no reset so it can map onto RAM primitives;
  // stale words are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count        <= w_count_next;
      r_full         <= (w_count_next == CW'(DEPTH));
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= CW'(AF_THRESH));
      r_almost_empty <= (w_count_next <= CW'(AE_THRESH));
    end
  end

  // Error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && r_full) r_overflow <= 1'b1;
      else if (clr_err)           r_overflow <= 1'b0;
      if (read_enable && r_empty) r_underflow <= 1'b1;
      else if (clr_err)           r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty.
      assign data_o     = r_empty ? '0 : r_mem[r_rd_ptr];
      assign data_valid = ~r_empty;
    end else begin : g_reg
      logic [DATA_W-1:0] r_data;
      logic              r_valid;

      always_ff @(posedge clk) begin
        if (!srst_n) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rd_acc;
          if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
        end
      end

      assign data_o     = r_data;
      assign data_valid = r_valid;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
